tl_ns_seq: RTL and testbench
============================

Name: tl_ns_seq

Overview:
- Next-state logic, state register and dwell timer for the left-turn traffic light controller.
- Produces the 3-bit current state {q2,q1,q0} consumed directly by the light output decoder o_logic.
- Advances through an 8-state cycle: A green, A yellow, A left, A yellow, then the same four phases for B.
- Advances only on a one-cycle tick enable, and bounds each dwell with minimum/maximum tick counts.

Parameters:
- CNT_W, 4, dwell counter width; must satisfy MAX_GRN < 2^CNT_W and MAX_LFT < 2^CNT_W.
- YEL_TICKS, 2, exact ticks spent in each yellow state; >= 1.
- MIN_GRN, 2, minimum ticks in a green or left state before a sensor may end it; >= 1.
- MAX_GRN, 6, forced exit from a green state (S0/S4) after this many ticks; >= MIN_GRN.
- MAX_LFT, 4, forced exit from a left state (S2/S6) after this many ticks; >= MIN_GRN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle timebase enable; state/counter change only when tick=1.
- Ta  in  1  traffic present on street A (straight).
- Tal  in  1  left-turn traffic present on A.
- Tb  in  1  traffic present on street B (straight).
- Tbl  in  1  left-turn traffic present on B.
- q2  out  1  current state bit 2, registered.
- q1  out  1  current state bit 1, registered.
- q0  out  1  current state bit 0, registered.
- phase_end  out  1  registered pulse, high for exactly one cycle after any state change.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=S0 (000), dwell count cnt=0, phase_end=0. Reset asserted mid-dwell returns to S0 immediately, without waiting for a clock edge.
- State encoding {q2,q1,q0}:
  - S0=000 A green; S1=001 A yellow; S2=010 A left; S3=011 A yellow.
  - S4=100 B green; S5=101 B yellow; S6=110 B left; S7=111 B yellow.
- Sequence: S0→S1→S2→S3→S4→S5→S6→S7→S0. No other transitions. The 3-bit encoding has no illegal codes.
- tick=0: state, cnt hold; phase_end=0.
- tick=1: compute n = cnt+1 and evaluate the exit condition for the current state:
  - S0: (n>=MIN_GRN && !Ta) || n>=MAX_GRN.
  - S4: (n>=MIN_GRN && !Tb) || n>=MAX_GRN.
  - S2: (n>=MIN_GRN && !Tal) || n>=MAX_LFT.
  - S6: (n>=MIN_GRN && !Tbl) || n>=MAX_LFT.
  - S1, S3, S5, S7: n>=YEL_TICKS.
- Exit true: state advances on that edge, cnt<=0, phase_end<=1 in the next cycle only.
- Exit false: cnt<=n, saturating at 2^CNT_W-1; phase_end<=0.
- Sensors are sampled only on tick cycles. Sensor changes between ticks have no effect.
- Latency: state change is visible on q one clock after the tick cycle that satisfies the exit condition.
- Simultaneous sensor drop and max timeout on the same tick: single exit, no double advance.
- Sensor-held green: forced exit at MAX_GRN, and the cycle continues normally.
- Arithmetic: n is computed in CNT_W+1 bits so that compares never wrap.

Decomposition:
- Shared package tl_pkg: the state encodings S0..S7 as 3-bit localparams, plus the default timing constants. o_logic tests reuse the same encodings.
- One sub-module, tl_dwell_cnt:
  - Inputs: clk, reset, tick, clr.
  - Output: cnt[CNT_W-1:0], saturating.
  - The top holds the state register, next-state/exit logic and the phase_end flop.

Test Plan:
- Reset during S2 with cnt=1, asserted between clock edges → q=000 immediately; after release, dwell restarts at cnt=0.
- Ta=0, Tal=0, ticks every cycle → S0 for 2 ticks, S1 for 2, S2 for 2, S3 for 2, then S4. phase_end pulses at each change.
- Ta=1 held, tick every 3 clocks → S0 exits on its 6th tick, q=001 one clock later; no exit before the 6th tick.
- Tal=1 held in S2 → forced exit on 4th tick to S3; then Tb=0, Tbl=1 → S4 lasts 2 ticks, S6 lasts 4 ticks, S7 then S0.
- Ta toggles 1→0→1 between ticks while tick=0 → no state or cnt change; only the value at tick edges matters.
- Full loop with all sensors 0 → exactly 16 ticks per S0..S7 cycle; q sequence 000,001,...,111,000. Each state's q matches the o_logic light decode (e.g. S4 gives La=11, Lb=00).

Source files
------------

// File: rtl/tl_pkg.sv
// Shared encodings and default timing for the left-turn traffic light controller.
// The state codes are also what the o_logic light decoder and its tests decode.
package tl_pkg;

  // {q2,q1,q0}: q2 selects street B, q1 the left phase, q0 a yellow.
  typedef enum logic [2:0] {
    S0 = 3'b000,  // A green
    S1 = 3'b001,  // A yellow
    S2 = 3'b010,  // A left
    S3 = 3'b011,  // A yellow
    S4 = 3'b100,  // B green
    S5 = 3'b101,  // B yellow
    S6 = 3'b110,  // B left
    S7 = 3'b111   // B yellow
  } tl_state_e;

  localparam int unsigned DEF_CNT_W     = 4;
  localparam int unsigned DEF_YEL_TICKS = 2;
  localparam int unsigned DEF_MIN_GRN   = 2;
  localparam int unsigned DEF_MAX_GRN   = 6;
  localparam int unsigned DEF_MAX_LFT   = 4;

  // The cycle is a plain increment; 111 wraps back to 000.
  function automatic tl_state_e tl_next_phase(input tl_state_e s);
    return tl_state_e'(s + 3'd1);
  endfunction

endpackage

// File: rtl/tl_dwell_cnt.sv
// Saturating dwell counter: counts tick cycles spent in the current phase
// and returns to zero on a tick that ends the phase.
module tl_dwell_cnt
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      if (clr) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_ns_seq.sv
// State register, exit logic and phase_end pulse for the eight-phase
// left-turn traffic light cycle; dwell timing lives in tl_dwell_cnt.
module tl_ns_seq
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned YEL_TICKS = DEF_YEL_TICKS,
  parameter int unsigned MIN_GRN   = DEF_MIN_GRN,
  parameter int unsigned MAX_GRN   = DEF_MAX_GRN,
  parameter int unsigned MAX_LFT   = DEF_MAX_LFT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic Ta,
  input  logic Tal,
  input  logic Tb,
  input  logic Tbl,
  output logic q2,
  output logic q1,
  output logic q0,
  output logic phase_end
);

  // Thresholds widened to CNT_W+1 so compares against n never wrap.
  localparam logic [CNT_W:0] YEL_N = (CNT_W + 1)'(YEL_TICKS);
  localparam logic [CNT_W:0] MIN_N = (CNT_W + 1)'(MIN_GRN);
  localparam logic [CNT_W:0] GRN_N = (CNT_W + 1)'(MAX_GRN);
  localparam logic [CNT_W:0] LFT_N = (CNT_W + 1)'(MAX_LFT);

  tl_state_e        state;
  tl_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   n;
  logic             exit_now;

  assign n = {1'b0, cnt} + 1'b1;

  tl_dwell_cnt #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .clr   (exit_now),
    .cnt   (cnt)
  );

  // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    exit_now  = 1'b0;
    state_nxt = state;
    case (state)
      S0:      exit_now = ((n >= MIN_N) && !Ta)  || (n >= GRN_N);
      S4:      exit_now = ((n >= MIN_N) && !Tb)  || (n >= GRN_N);
      S2:      exit_now = ((n >= MIN_N) && !Tal) || (n >= LFT_N);
      S6:      exit_now = ((n >= MIN_N) && !Tbl) || (n >= LFT_N);
      default: exit_now = (n >= YEL_N);
    endcase
    if (tick && exit_now) begin
      state_nxt = tl_next_phase(state);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S0;
      phase_end <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_end <= tick && exit_now;
    end
  end

  assign {q2, q1, q0} = state;

endmodule

// File: tb/tb_tl_ns_seq.sv
// Directed bench for tl_ns_seq with default timing (YEL 2, MIN 2, MAX_GRN 6, MAX_LFT 4).
// Each step drives tick for one clock and compares {q2,q1,q0,phase_end} 1 ns after the edge.
module tb_tl_ns_seq;

  logic clk = 1'b0;
  logic reset;
  logic tick;
  logic Ta, Tal, Tb, Tbl;
  logic q2, q1, q0, phase_end;

  int checks = 0;
  int errors = 0;

  tl_ns_seq dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .Ta        (Ta),
    .Tal       (Tal),
    .Tb        (Tb),
    .Tbl       (Tbl),
    .q2        (q2),
    .q1        (q1),
    .q0        (q0),
    .phase_end (phase_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed q,pe=%b expected q,pe=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t, input logic [2:0] exp_q, input logic exp_pe,
                      input string tag);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
    check(tag, {q2, q1, q0, phase_end}, {exp_q, exp_pe});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset = 1'b1;
    tick  = 1'b0;
    Ta = 1'b0; Tal = 1'b0; Tb = 1'b1; Tbl = 1'b1;
    #12;
    check("reset_state", {q2, q1, q0, phase_end}, 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // A side with no traffic: every phase lasts the 2-tick minimum.
    step(1, 3'b000, 0, "s0_t1");
    step(1, 3'b001, 1, "s0_exit");
    step(1, 3'b001, 0, "s1_t1");
    step(1, 3'b010, 1, "s1_exit");
    step(1, 3'b010, 0, "s2_t1");
    step(1, 3'b011, 1, "s2_exit");
    step(1, 3'b011, 0, "s3_t1");
    step(1, 3'b100, 1, "s3_exit");

    // B straight clears, B left held: S4 for 2 ticks, S6 forced out on tick 4.
    Tb = 1'b0;
    step(1, 3'b100, 0, "s4_t1");
    step(1, 3'b101, 1, "s4_exit");
    step(1, 3'b101, 0, "s5_t1");
    step(1, 3'b110, 1, "s5_exit");
    for (int k = 1; k <= 3; k++) step(1, 3'b110, 0, $sformatf("s6_hold_t%0d", k));
    step(1, 3'b111, 1, "s6_max");
    step(1, 3'b111, 0, "s7_t1");
    step(1, 3'b000, 1, "s7_exit");

    // Ta held, tick every 3 clocks; a Ta dip between ticks must be ignored.
    Ta = 1'b1; Tal = 1'b1; Tb = 1'b1; Tbl = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1, 3'b000, 0, $sformatf("s0_held_t%0d", k));
      if (k == 3) Ta = 1'b0;
      step(0, 3'b000, 0, $sformatf("s0_idle_a%0d", k));
      Ta = 1'b1;
      step(0, 3'b000, 0, $sformatf("s0_idle_b%0d", k));
    end
    step(1, 3'b001, 1, "s0_max");
    step(0, 3'b001, 0, "pe_one_cycle");

    // A left held: forced out of S2 on tick 4.
    step(1, 3'b001, 0, "s1b_t1");
    step(1, 3'b010, 1, "s1b_exit");
    for (int k = 1; k <= 3; k++) step(1, 3'b010, 0, $sformatf("s2_hold_t%0d", k));
    step(1, 3'b011, 1, "s2_max");
    step(1, 3'b011, 0, "s3b_t1");
    step(1, 3'b100, 1, "s3b_exit");

    // Tb drops on the same tick as the max timeout: exactly one advance.
    for (int k = 1; k <= 5; k++) step(1, 3'b100, 0, $sformatf("s4_held_t%0d", k));
    Tb = 1'b0;
    step(1, 3'b101, 1, "s4_drop_and_max");
    step(1, 3'b101, 0, "s5_no_double");
    Tbl = 1'b0;
    step(1, 3'b110, 1, "s5b_exit");
    step(1, 3'b110, 0, "s6b_t1");
    step(1, 3'b111, 1, "s6b_exit");
    step(1, 3'b111, 0, "s7b_t1");
    step(1, 3'b000, 1, "s7b_exit");

    // Full loop with no traffic: 16 ticks, state = ticks/2.
    Ta = 1'b0; Tal = 1'b0; Tb = 1'b0; Tbl = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      logic [2:0] eq;
      eq = 3'(k / 2);
      step(1, eq, (k % 2) == 0, $sformatf("loop_t%0d", k));
    end

    // Reach S2 with cnt=1, then reset between edges.
    step(1, 3'b000, 0, "pre_rst_t1");
    step(1, 3'b001, 1, "pre_rst_t2");
    step(1, 3'b001, 0, "pre_rst_t3");
    step(1, 3'b010, 1, "pre_rst_t4");
    step(1, 3'b010, 0, "pre_rst_t5");
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {q2, q1, q0, phase_end}, 4'b0000);
    #1;
    reset = 1'b0;
    step(1, 3'b000, 0, "post_rst_t1");
    step(1, 3'b001, 1, "post_rst_exit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
